// File: rtl/seq_alu_pkg.sv
// seq_alu_pkg: shared types and constants for the sequential ALU.
//   func_e  - 4-bit operation codes (10..15 are illegal)
//   state_e - control FSM states
//   flags_t - registered status flags
package seq_alu_pkg;

    localparam int FUNC_W = 4;

    typedef enum logic [FUNC_W-1:0] {
        FN_ADD  = 4'd0,
        FN_SUB  = 4'd1,
        FN_NOT  = 4'd2,
        FN_AND  = 4'd3,
        FN_OR   = 4'd4,
        FN_XOR  = 4'd5,
        FN_SLT  = 4'd6,
        FN_EQ   = 4'd7,
        FN_SLTU = 4'd8,
        FN_MUL  = 4'd9
    } func_e;

    typedef enum logic [1:0] {
        ST_IDLE = 2'd0,
        ST_BUSY = 2'd1,
        ST_DONE = 2'd2
    } state_e;

    typedef struct packed {
        logic carry;
        logic overflow;
        logic zero;
        logic negative;
        logic err;
    } flags_t;

endpackage

// File: rtl/seq_alu_mul.sv
// seq_alu_mul: iterative unsigned shift-add multiplier, one multiplier bit
// per clock, 2*WIDTH accumulator.
//   start      - load operands (pulse, only while idle)
//   a, b       - multiplicand / multiplier
//   flush      - abandon the current product
//   done       - high during the last iteration; lo/hi_nonzero are valid
//                in that same cycle so the caller can register them
//   lo         - low WIDTH bits of the product
//   hi_nonzero - high WIDTH bits of the product are non-zero
module seq_alu_mul #(
    parameter int WIDTH = 32
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic             start,
    input  logic             flush,
    input  logic [WIDTH-1:0] a,
    input  logic [WIDTH-1:0] b,
    output logic             done,
    output logic [WIDTH-1:0] lo,
    output logic             hi_nonzero
);
    localparam int CNT_W = $clog2(WIDTH);
    localparam logic [CNT_W-1:0] LAST = CNT_W'(WIDTH - 1);

    logic               busy_q,   busy_d;
    logic [CNT_W-1:0]   cnt_q,    cnt_d;
    logic [2*WIDTH-1:0] mcand_q,  mcand_d;
    logic [WIDTH-1:0]   mplier_q, mplier_d;
    logic [2*WIDTH-1:0] acc_q,    acc_d;
    logic [2*WIDTH-1:0] acc_sum;

    always_comb begin
        // Partial product for this iteration: multiplicand already shifted
        // to the weight of the current multiplier bit.
        acc_sum    = acc_q + (mplier_q[0] ? mcand_q : '0);
        done       = busy_q && (cnt_q == LAST);
        lo         = acc_sum[WIDTH-1:0];
        hi_nonzero = |acc_sum[2*WIDTH-1:WIDTH];

        busy_d   = busy_q;
        cnt_d    = cnt_q;
        mcand_d  = mcand_q;
        mplier_d = mplier_q;
        acc_d    = acc_q;

        if (busy_q) begin
            acc_d    = acc_sum;
            mcand_d  = mcand_q << 1;
            mplier_d = mplier_q >> 1;
            cnt_d    = cnt_q + 1'b1;
            if (done) busy_d = 1'b0;
        end
        if (start) begin
            busy_d   = 1'b1;
            cnt_d    = '0;
            mcand_d  = {{WIDTH{1'b0}}, a};
            mplier_d = b;
            acc_d    = '0;
        end
        if (flush) busy_d = 1'b0;
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            busy_q   <= 1'b0;
            cnt_q    <= '0;
            mcand_q  <= '0;
            mplier_q <= '0;
            acc_q    <= '0;
        end else begin
            busy_q   <= busy_d;
            cnt_q    <= cnt_d;
            mcand_q  <= mcand_d;
            mplier_q <= mplier_d;
            acc_q    <= acc_d;
        end
    end

endmodule

// File: rtl/seq_alu.sv
// seq_alu: registered ALU with valid/ready handshake on input and output.
//   clk, rst_n           - clock, async active-low reset
//   flush                - synchronous abort back to IDLE (highest priority)
//   in_valid/in_ready    - request handshake; in_ready only in IDLE
//   a, b, func           - operands and operation code
//   out_valid/out_ready  - response handshake
//   result, carry, overflow, zero, negative, err - registered response
// Build option: define SEQ_ALU_MUL_EN to enable the iterative MUL (func 9);
// otherwise func 9 is treated as illegal.
module seq_alu
    import seq_alu_pkg::*;
#(
    parameter int WIDTH = 32
) (
    input  logic              clk,
    input  logic              rst_n,
    input  logic              flush,
    input  logic              in_valid,
    output logic              in_ready,
    input  logic [WIDTH-1:0]  a,
    input  logic [WIDTH-1:0]  b,
    input  logic [FUNC_W-1:0] func,
    output logic              out_valid,
    input  logic              out_ready,
    output logic [WIDTH-1:0]  result,
    output logic              carry,
    output logic              overflow,
    output logic              zero,
    output logic              negative,
    output logic              err
);
    localparam int MSB = WIDTH - 1;

    state_e           state_q,  state_d;
    logic [WIDTH-1:0] result_q, result_d;
    flags_t           flags_q,  flags_d;

    // Single-cycle datapath, evaluated on the live inputs; it is only
    // registered on the acceptance edge, which captures the operands.
    logic             sub;
    logic [WIDTH-1:0] bx;
    logic [WIDTH:0]   sum;
    logic [WIDTH-1:0] alu_res;
    logic             alu_c, alu_v, alu_err;
    logic             is_mul;

    always_comb begin
        sub     = (func == FN_SUB);
        bx      = b ^ {WIDTH{sub}};
        sum     = {1'b0, a} + {1'b0, bx} + {{WIDTH{1'b0}}, sub};
        alu_res = '0;
        alu_c   = 1'b0;
        alu_v   = 1'b0;
        alu_err = 1'b0;
        case (func_e'(func))
            FN_ADD, FN_SUB: begin
                alu_res = sum[WIDTH-1:0];
                alu_c   = sum[WIDTH];
                alu_v   = (a[MSB] == bx[MSB]) && (sum[MSB] != a[MSB]);
            end
            FN_NOT:  alu_res = ~a;
            FN_AND:  alu_res = a & b;
            FN_OR:   alu_res = a | b;
            FN_XOR:  alu_res = a ^ b;
            FN_SLT:  alu_res = WIDTH'($signed(a) < $signed(b));
            FN_EQ:   alu_res = WIDTH'(a == b);
            FN_SLTU: alu_res = WIDTH'(a < b);
            default: alu_err = 1'b1;  // includes MUL, which is routed elsewhere when enabled
        endcase
    end

`ifdef SEQ_ALU_MUL_EN
    logic             mul_start;
    logic             mul_done;
    logic [WIDTH-1:0] mul_lo;
    logic             mul_hi_nz;

    assign is_mul = (func == FN_MUL);

    seq_alu_mul #(.WIDTH(WIDTH)) u_mul (
        .clk        (clk),
        .rst_n      (rst_n),
        .start      (mul_start),
        .flush      (flush),
        .a          (a),
        .b          (b),
        .done       (mul_done),
        .lo         (mul_lo),
        .hi_nonzero (mul_hi_nz)
    );
`else
    assign is_mul = 1'b0;
`endif

    always_comb begin
        state_d  = state_q;
        result_d = result_q;
        flags_d  = flags_q;
`ifdef SEQ_ALU_MUL_EN
        mul_start = 1'b0;
`endif
        case (state_q)
            ST_IDLE: begin
                if (in_valid) begin
                    if (is_mul) begin
`ifdef SEQ_ALU_MUL_EN
                        mul_start = 1'b1;
                        state_d   = ST_BUSY;
`endif
                    end else begin
                        state_d          = ST_DONE;
                        result_d         = alu_res;
                        flags_d.carry    = alu_c;
                        flags_d.overflow = alu_v;
                        // Illegal ops report only err; zero must not follow result == 0.
                        flags_d.zero     = !alu_err && (alu_res == '0);
                        flags_d.negative = !alu_err && alu_res[MSB];
                        flags_d.err      = alu_err;
                    end
                end
            end
`ifdef SEQ_ALU_MUL_EN
            ST_BUSY: begin
                if (mul_done) begin
                    state_d          = ST_DONE;
                    result_d         = mul_lo;
                    flags_d.carry    = mul_hi_nz;
                    flags_d.overflow = 1'b0;
                    flags_d.zero     = (mul_lo == '0);
                    flags_d.negative = mul_lo[MSB];
                    flags_d.err      = 1'b0;
                end
            end
`endif
            ST_DONE: begin
                if (out_ready) state_d = ST_IDLE;
            end
            default: state_d = ST_IDLE;
        endcase

        // Flush wins over everything: no acceptance, no result load.
        if (flush) begin
            state_d  = ST_IDLE;
            result_d = result_q;
            flags_d  = flags_q;
`ifdef SEQ_ALU_MUL_EN
            mul_start = 1'b0;
`endif
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q  <= ST_IDLE;
            result_q <= '0;
            flags_q  <= '0;
        end else begin
            state_q  <= state_d;
            result_q <= result_d;
            flags_q  <= flags_d;
        end
    end

    assign in_ready  = (state_q == ST_IDLE);
    assign out_valid = (state_q == ST_DONE);
    assign result    = result_q;
    assign carry     = flags_q.carry;
    assign overflow  = flags_q.overflow;
    assign zero      = flags_q.zero;
    assign negative  = flags_q.negative;
    assign err       = flags_q.err;

endmodule

// File: tb/tb_seq_alu.sv
// tb_seq_alu: directed + random checks of seq_alu at WIDTH = 8 against an
// arithmetic reference model. Honours SEQ_ALU_MUL_EN for func 9.
module tb_seq_alu;
    localparam int W = 8;
`ifdef SEQ_ALU_MUL_EN
    localparam bit MUL_EN = 1'b1;
`else
    localparam bit MUL_EN = 1'b0;
`endif

    logic         clk = 1'b0;
    logic         rst_n, flush, in_valid, in_ready, out_valid, out_ready;
    logic [W-1:0] a, b, result;
    logic [3:0]   func;
    logic         carry, overflow, zero, negative, err;

    int n_vec = 0;
    int n_err = 0;

    always #5 clk = ~clk;

    seq_alu #(.WIDTH(W)) dut (
        .clk       (clk),
        .rst_n     (rst_n),
        .flush     (flush),
        .in_valid  (in_valid),
        .in_ready  (in_ready),
        .a         (a),
        .b         (b),
        .func      (func),
        .out_valid (out_valid),
        .out_ready (out_ready),
        .result    (result),
        .carry     (carry),
        .overflow  (overflow),
        .zero      (zero),
        .negative  (negative),
        .err       (err)
    );

    typedef struct packed {
        logic [7:0] r;
        logic       c, v, z, n, e;   // carry, overflow, zero, negative, err
    } exp_t;

    // Reference model from the operation rules, using plain integers.
    function automatic exp_t model(input int ua, input int ub, input int f);
        exp_t e;
        int   sa, sb, r, s;
        e  = '0;
        sa = (ua >= 128) ? ua - 256 : ua;
        sb = (ub >= 128) ? ub - 256 : ub;
        r  = 0;
        case (f)
            0: begin r = ua + ub; e.c = (r > 255); s = sa + sb; e.v = (s > 127) || (s < -128); end
            1: begin r = ua - ub; e.c = (ua >= ub); s = sa - sb; e.v = (s > 127) || (s < -128); end
            2: r = ~ua;
            3: r = ua & ub;
            4: r = ua | ub;
            5: r = ua ^ ub;
            6: r = (sa < sb) ? 1 : 0;
            7: r = (ua == ub) ? 1 : 0;
            8: r = (ua < ub) ? 1 : 0;
            9: begin
                if (!MUL_EN) begin e.e = 1'b1; return e; end
                r = ua * ub; e.c = (r > 255);
            end
            default: begin e.e = 1'b1; return e; end
        endcase
        e.r = r[7:0];
        e.z = (e.r == 8'h00);
        e.n = e.r[7];
        return e;
    endfunction

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_vec++;
        assert (obs === exp) else begin
            n_err++;
            $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
        end
    endtask

    task automatic chk_resp(input string tag, input exp_t e);
        chk({tag, ".result"}, 32'(result), 32'(e.r));
        chk({tag, ".flags"}, 32'({carry, overflow, zero, negative, err}),
            32'({e.c, e.v, e.z, e.n, e.e}));
    endtask

    // Presents one request; returns #1 after the acceptance edge.
    task automatic start_op(input logic [7:0] ta, input logic [7:0] tb, input logic [3:0] tf);
        @(negedge clk);
        a = ta; b = tb; func = tf; in_valid = 1'b1;
        chk("in_ready_before", 32'(in_ready), 32'd1);
        @(posedge clk); #1;
        in_valid = 1'b0;
        // Scramble inputs after acceptance: must not affect the result.
        a = 8'($urandom); b = 8'($urandom); func = 4'($urandom);
    endtask

    task automatic run_op(input logic [7:0] ta, input logic [7:0] tb, input logic [3:0] tf,
                          input int hold);
        exp_t e;
        int   lat, exp_lat;
        e       = model(int'(ta), int'(tb), int'(tf));
        exp_lat = (tf == 4'd9 && MUL_EN) ? W : 1;
        start_op(ta, tb, tf);
        lat = 1;
        while (!out_valid && lat < 40) begin
            @(posedge clk); #1;
            lat++;
        end
        chk($sformatf("latency f%0d", tf), 32'(lat), 32'(exp_lat));
        chk_resp($sformatf("op f%0d %h,%h", tf, ta, tb), e);
        for (int i = 0; i < hold; i++) begin
            @(negedge clk);
            chk("hold.valid", 32'(out_valid), 32'd1);
            chk("hold.in_ready", 32'(in_ready), 32'd0);
            chk_resp("hold", e);
        end
        @(negedge clk); out_ready = 1'b1;
        @(posedge clk); #1; out_ready = 1'b0;
        chk("post_ack.valid", 32'(out_valid), 32'd0);
        chk("post_ack.in_ready", 32'(in_ready), 32'd1);
    endtask

    initial begin
        rst_n = 1'b0; flush = 1'b0; in_valid = 1'b0; out_ready = 1'b0;
        a = '0; b = '0; func = '0;
        repeat (2) @(posedge clk); #1;
        chk("rst.out_valid", 32'(out_valid), 32'd0);
        chk("rst.in_ready", 32'(in_ready), 32'd1);
        chk_resp("rst", '0);
        @(negedge clk); rst_n = 1'b1;

        // Directed cases
        run_op(8'h7F, 8'h01, 4'd0, 0);
        run_op(8'h03, 8'h05, 4'd1, 0);
        run_op(8'h05, 8'h05, 4'd1, 0);
        run_op(8'h00, 8'h80, 4'd1, 0);
        run_op(8'hFF, 8'h01, 4'd6, 0);
        run_op(8'hFF, 8'h01, 4'd8, 0);
        run_op(8'h5A, 8'h5A, 4'd7, 0);
        run_op(8'h10, 8'h20, 4'd9, 3);
        run_op(8'h0F, 8'h0D, 4'd9, 0);
        run_op(8'h12, 8'h34, 4'hF, 0);
        run_op(8'h12, 8'h34, 4'd9, 1);

        // Flush while an op is in flight (4th BUSY cycle for MUL, DONE otherwise)
        start_op(8'h10, 8'h20, (MUL_EN ? 4'd9 : 4'd0));
        if (MUL_EN) begin
            repeat (3) @(posedge clk);
            #1;
        end
        flush = 1'b1;
        @(posedge clk); #1; flush = 1'b0;
        chk("flush.valid", 32'(out_valid), 32'd0);
        chk("flush.in_ready", 32'(in_ready), 32'd1);
        for (int i = 0; i < 10; i++) begin
            @(posedge clk); #1;
            chk("flush.quiet", 32'(out_valid), 32'd0);
        end
        run_op(8'h01, 8'h01, 4'd0, 0);

        // flush together with in_valid in IDLE: not accepted
        @(negedge clk); a = 8'h22; b = 8'h11; func = 4'd0; in_valid = 1'b1; flush = 1'b1;
        @(posedge clk); #1; in_valid = 1'b0; flush = 1'b0;
        chk("flush_idle.valid", 32'(out_valid), 32'd0);
        chk("flush_idle.in_ready", 32'(in_ready), 32'd1);
        @(posedge clk); #1;
        chk("flush_idle.valid2", 32'(out_valid), 32'd0);

        // Reset in the middle of an op
        start_op(8'h10, 8'h20, (MUL_EN ? 4'd9 : 4'd0));
        if (MUL_EN) begin
            repeat (3) @(posedge clk);
            #1;
        end
        rst_n = 1'b0; #1;
        chk("midrst.out_valid", 32'(out_valid), 32'd0);
        chk("midrst.in_ready", 32'(in_ready), 32'd1);
        chk_resp("midrst", '0);
        @(negedge clk); rst_n = 1'b1;
        run_op(8'h01, 8'h01, 4'd0, 0);

        // Random operations against the model
        for (int i = 0; i < 60; i++) begin
            run_op(8'($urandom), 8'($urandom), 4'($urandom_range(0, 15)),
                   int'($urandom_range(0, 2)));
        end

        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
        $finish;
    end

endmodule
